// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the master-facing and slave-facing Wishbone signals of the round-robin arbiter.
// Latency: none, wires only.
// Backpressure: none here; the arbiter holds masters off by withholding ack until they are granted.
//
// Modports:
//   slave  - arbiter view: it serves the masters and drives the shared slave-side bus.
//   master - environment view: the requesting masters plus the downstream slave.
interface wb_rr_arbiter_if #(
    parameter int N_MASTERS = 4
);
    // master side, flattened: master k occupies [32k+31:32k] / [4k+3:4k]
    logic [N_MASTERS-1:0]    m_cyc_i;
    logic [N_MASTERS-1:0]    m_stb_i;
    logic [N_MASTERS-1:0]    m_we_i;
    logic [32*N_MASTERS-1:0] m_adr_i;
    logic [32*N_MASTERS-1:0] m_dat_i;
    logic [4*N_MASTERS-1:0]  m_sel_i;
    logic [31:0]             m_dat_o;
    logic [N_MASTERS-1:0]    m_ack_o;
    logic [N_MASTERS-1:0]    m_err_o;
    // shared slave side
    logic                    s_cyc_o;
    logic                    s_stb_o;
    logic                    s_we_o;
    logic [31:0]             s_adr_o;
    logic [31:0]             s_dat_o;
    logic [3:0]              s_sel_o;
    logic [31:0]             s_dat_i;
    logic                    s_ack_i;
    // status
    logic [N_MASTERS-1:0]    gnt_o;
    logic                    busy_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
               s_sel_o, gnt_o, busy_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
               s_sel_o, gnt_o, busy_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one granted master owns the slave bus for its whole cyc, with a strobe watchdog.
// Latency: 1 cycle from cyc to grant, 1 idle cycle between grants; ack/data pass through combinationally.
// Backpressure: waiting masters see no ack until granted; a stalled slave is cut off with a 1-cycle err.
//
// Ports: clk (rising edge), rst (async, active low), bus (wb_rr_arbiter_if.slave):
//   m_* per-master request/response, s_* shared slave bus, gnt_o one-hot grant, busy_o grant/err active.
module wb_rr_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    wb_rr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int CW    = IDX_W + 1;
    localparam logic [N_MASTERS-1:0] GNT_ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t               state_q;
    logic [N_MASTERS-1:0] gnt_q;
    logic [N_MASTERS-1:0] err_q;
    logic                 busy_q;
    logic [IDX_W-1:0]     gidx_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic [CW-1:0]        cand;
    logic [IDX_W-1:0]     ptr_d;

    // Scan from the far end back toward ptr so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(N_MASTERS)) begin
                cand = cand - CW'(N_MASTERS);
            end
            if (bus.m_cyc_i[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // After a grant ends, the master just served drops to lowest priority.
    assign ptr_d = (gidx_q == IDX_W'(N_MASTERS - 1)) ? '0 : gidx_q + IDX_W'(1);

    // Slave bus is driven only in GRANT; IDLE and ERR keep every control low.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.m_ack_o = '0;
        if (state_q == GRANT) begin
            bus.s_cyc_o = bus.m_cyc_i[gidx_q];
            bus.s_stb_o = bus.m_stb_i[gidx_q];
            bus.s_we_o  = bus.m_we_i[gidx_q];
            bus.s_adr_o = bus.m_adr_i[32*int'(gidx_q) +: 32];
            bus.s_dat_o = bus.m_dat_i[32*int'(gidx_q) +: 32];
            bus.s_sel_o = bus.m_sel_i[4*int'(gidx_q) +: 4];
            bus.m_ack_o = gnt_q & {N_MASTERS{bus.s_ack_i}};
        end
    end

    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_err_o = err_q;
    assign bus.gnt_o   = gnt_q;
    assign bus.busy_o  = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            err_q <= '0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (pick_vld) begin
                        state_q <= GRANT;
                        gidx_q  <= pick_idx;
                        gnt_q   <= GNT_ONE << pick_idx;
                        busy_q  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!bus.m_cyc_i[gidx_q]) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                        cnt_q   <= '0;
                    end else if (bus.s_stb_o && !bus.s_ack_i) begin
                        // An ack on the limit cycle takes the else branch, so it always beats the watchdog.
                        if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                            state_q <= ERR;
                            err_q   <= gnt_q;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                ERR: begin
                    cnt_q <= '0;
                    if (bus.m_cyc_i[gidx_q]) begin
                        state_q <= GRANT;
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized bench for wb_rr_arbiter: bursty masters and a slave with random ack delay or no ack at all.
// Latency: grants expected 1 cycle after request, responses checked in the cycle they appear.
// Backpressure: waiting masters keep cyc high until served; stimulus and checking run as separate processes.
module tb_wb_rr_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.N_MASTERS(N)) bus ();

    wb_rr_arbiter #(.N_MASTERS(N), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_err;
        int          m;
        logic [31:0] rdat;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        we;
    } exp_t;

    exp_t           rsp_q[$];
    logic [N-1:0]   gnt_exp_q[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    bit             done  = 0;

    // reference model state
    int             ptr_m;
    int             pend[N];
    logic [31:0]    madr[N];
    logic [31:0]    mdat[N];
    logic [3:0]     msel[N];
    logic           mwe[N];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] got);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h expected nothing", name, got);
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Next owner: first requesting master at ptr, ptr+1, ... wrapping modulo N.
    function automatic int pick();
        for (int i = 0; i < N; i++) begin
            if (pend[(ptr_m + i) % N] > 0) return (ptr_m + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_masters();
        for (int k = 0; k < N; k++) begin
            bus.m_adr_i[32*k +: 32] = madr[k];
            bus.m_dat_i[32*k +: 32] = mdat[k];
            bus.m_sel_i[4*k +: 4]   = msel[k];
            bus.m_we_i[k]           = mwe[k];
        end
    endtask

    task automatic randomize_masters();
        for (int k = 0; k < N; k++) begin
            madr[k] = $urandom;
            mdat[k] = $urandom;
            msel[k] = 4'($urandom_range(0, 15));
            mwe[k]  = 1'($urandom_range(0, 1));
        end
        drive_masters();
    endtask

    // Monitor: grants and responses are compared against the queues as the DUT presents them.
    initial begin
        logic [N-1:0] prev_gnt;
        exp_t         e;
        prev_gnt = '0;
        while (!done) begin
            @(negedge clk);
            if (bus.gnt_o !== prev_gnt && bus.gnt_o !== '0) begin
                if (gnt_exp_q.size() == 0) unexpected("grant", 128'(bus.gnt_o));
                else check("grant", 128'(bus.gnt_o), 128'(gnt_exp_q.pop_front()));
            end
            prev_gnt = bus.gnt_o;
            if ((|bus.m_ack_o) || (|bus.m_err_o)) begin
                if (rsp_q.size() == 0) begin
                    unexpected("response", 128'({bus.m_ack_o, bus.m_err_o}));
                end else begin
                    e = rsp_q.pop_front();
                    if (e.is_err) begin
                        check("err_hs", 128'({bus.m_ack_o, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o}),
                              128'({{N{1'b0}}, onehot(e.m), 2'b00}));
                    end else begin
                        check("ack_hs", 128'({bus.m_ack_o, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o}),
                              128'({onehot(e.m), {N{1'b0}}, 2'b11}));
                        check("ack_bus", 128'({bus.m_dat_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o}),
                              128'({e.rdat, e.adr, e.wdat, e.sel, e.we}));
                    end
                end
            end
        end
    end

    // Stimulus and reference model
    initial begin
        int   g;
        int   nb;
        int   gap;
        int   mode;
        int   d;
        int   k;
        bit   dropped;
        bit   any;
        exp_t e;

        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 128'({bus.gnt_o, bus.busy_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o,
                                   bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.m_ack_o, bus.m_err_o}), '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        ptr_m = 0;

        for (int r = 0; r < 40; r++) begin
            any = 0;
            for (int i = 0; i < N; i++) begin
                if (pend[i] == 0 && $urandom_range(0, 2) == 0) pend[i] = $urandom_range(1, 2);
                if (pend[i] > 0) any = 1;
            end
            if (!any) pend[$urandom_range(0, N-1)] = 1;
            for (int i = 0; i < N; i++) bus.m_cyc_i[i] = (pend[i] > 0);
            g = pick();
            gnt_exp_q.push_back(onehot(g));
            @(posedge clk);
            #1;
            check("busy_in_grant", 128'(bus.busy_o), 128'(1));

            nb      = $urandom_range(1, 4);
            dropped = 0;
            for (int b = 0; b < nb; b++) begin
                randomize_masters();
                bus.m_stb_i = '0;
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                k = $urandom_range(0, N-1);
                if (k != g && pend[k] == 0 && $urandom_range(0, 2) == 0) begin
                    pend[k]        = 1;
                    bus.m_cyc_i[k] = 1'b1;
                end
                mode = $urandom_range(0, 5);
                e.m    = g;
                e.adr  = madr[g];
                e.wdat = mdat[g];
                e.sel  = msel[g];
                e.we   = mwe[g];
                if (mode == 0) begin
                    // slave never answers: watchdog fires after TO strobe cycles
                    e.is_err = 1;
                    e.rdat   = '0;
                    rsp_q.push_back(e);
                    bus.m_stb_i[g] = 1'b1;
                    repeat (TO) begin
                        @(posedge clk);
                        #1;
                    end
                    bus.m_stb_i[g] = 1'b0;
                    if (b == nb - 1) begin
                        bus.m_cyc_i[g] = 1'b0;
                        dropped        = 1;
                    end
                    @(posedge clk);
                    #1;
                end else begin
                    d        = (mode == 1) ? TO - 1 : $urandom_range(0, 3);
                    e.is_err = 0;
                    e.rdat   = $urandom;
                    rsp_q.push_back(e);
                    bus.m_stb_i[g] = 1'b1;
                    for (int i = 0; i <= d; i++) begin
                        bus.s_ack_i = (i == d);
                        bus.s_dat_i = (i == d) ? e.rdat : $urandom;
                        @(posedge clk);
                        #1;
                    end
                    bus.s_ack_i    = 1'b0;
                    bus.m_stb_i[g] = 1'b0;
                end
            end
            if (!dropped) begin
                bus.m_cyc_i[g] = 1'b0;
                @(posedge clk);
                #1;
            end
            check("idle_gap", 128'({bus.gnt_o, bus.busy_o}), '0);
            pend[g]--;
            ptr_m = (g + 1) % N;
        end

        // Reset in the middle of a stalled transfer, then priority restarts at master 0.
        for (int i = 0; i < N; i++) pend[i] = (i == 1) ? 1 : 0;
        bus.m_cyc_i = 4'b0010;
        g = pick();
        gnt_exp_q.push_back(onehot(g));
        @(posedge clk);
        #1;
        bus.m_cyc_i    = '1;
        bus.m_stb_i[g] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("reset_async", 128'({bus.s_cyc_o, bus.s_stb_o, bus.gnt_o, bus.busy_o, bus.m_ack_o, bus.m_err_o}), '0);
        bus.m_stb_i = '0;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < N; i++) pend[i] = 1;
        gnt_exp_q.push_back(onehot(pick()));
        @(posedge clk);
        #1;
        bus.m_cyc_i = '0;
        repeat (3) @(posedge clk);
        #1;

        check("grants_drained", 128'(gnt_exp_q.size()), '0);
        check("responses_drained", 128'(rsp_q.size()), '0);
        done = 1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that shares one slave-side bus port among N masters. Example: LM32 instruction and data ports plus DMA-capable peripherals in front of the address-decoding interconnect.
- Grants one master at a time and holds the grant for that master's whole Wishbone cycle (cyc high).
- Enforces a bus watchdog: a stalled slave is terminated with an error to the granted master.
- Sits between the CPU/master ports and the slave decoder; clocked by the system clock.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..8).
- TIMEOUT, 255, max cycles a strobe may wait for ack before watchdog error (1..65535).
- CNT_W, 16, watchdog counter width; must hold TIMEOUT.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- m_cyc_i  input  N_MASTERS  per-master cycle request.
- m_stb_i  input  N_MASTERS  per-master strobe.
- m_we_i  input  N_MASTERS  per-master write enable.
- m_adr_i  input  32*N_MASTERS  flattened addresses; master k at [32k+31:32k].
- m_dat_i  input  32*N_MASTERS  flattened write data.
- m_sel_i  input  4*N_MASTERS  flattened byte selects.
- m_dat_o  output  32  read data, broadcast to all masters (= s_dat_i).
- m_ack_o  output  N_MASTERS  per-master ack.
- m_err_o  output  N_MASTERS  per-master watchdog error.
- s_cyc_o, s_stb_o, s_we_o  output  1 each  slave-side controls.
- s_adr_o  output  32  slave-side address.
- s_dat_o  output  32  slave-side write data.
- s_sel_o  output  4  slave-side byte select.
- s_dat_i  input  32  slave read data.
- s_ack_i  input  1  slave ack.
- gnt_o  output  N_MASTERS  registered one-hot grant (debug/status).
- busy_o  output  1  high while state is GRANT or ERR.

Behaviour:
- Reset (rst low, asynchronous):
  - State is IDLE; gnt_o=0; priority pointer ptr=0 (master 0 highest).
  - Watchdog count=0; all s_* controls 0; m_ack_o=0; m_err_o=0; busy_o=0.
  - A reset asserted mid-transfer drops s_cyc_o/s_stb_o immediately. No ack or err is produced for the aborted transfer.
- State IDLE:
  - If any m_cyc_i is high, select the first requester scanning ptr, ptr+1, ... modulo N_MASTERS.
  - Register its one-hot grant into gnt_o and go to GRANT. Arbitration latency is exactly 1 cycle from cyc seen to gnt_o.
  - If no request is present, stay in IDLE.
- State GRANT:
  - Slave-side outputs are combinational muxes of the granted master's signals: s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g], with we/adr/dat/sel taken from master g.
  - Non-granted masters see ack=0 and err=0. m_ack_o[g]=s_ack_i, combinational, zero added latency.
  - Burst/locked sequences are supported: the grant is held while m_cyc_i[g] stays high, regardless of stb gaps.
  - When m_cyc_i[g] is low at a clock edge: clear gnt_o, set ptr=(g+1) mod N_MASTERS, go to IDLE. There is one idle bus cycle between grants.
- Watchdog:
  - In GRANT, count increments each cycle with s_stb_o=1 and s_ack_i=0.
  - count clears on s_ack_i, when stb is low, or on leaving GRANT.
  - When count==TIMEOUT-1 and still no ack, go to ERR.
- State ERR (exactly 1 cycle):
  - m_err_o[g]=1; s_cyc_o=0 and s_stb_o=0 (forced); m_ack_o=0.
  - Next state: GRANT if m_cyc_i[g] is still high, else IDLE with the ptr update.
- Simultaneous events:
  - An ack in the same cycle the count would reach the limit wins: no error.
  - A cyc drop in the same cycle as the ack completes normally.
  - New requests arriving during GRANT wait; they are never preempted.
- Out-of-range requests: m_cyc_i bits beyond N_MASTERS are not applicable; the width is exact.

Test Plan:
- Reset, then m_cyc_i=4'b0001 single read with s_ack_i after 2 cycles, s_dat_i=32'hDEADBEEF -> gnt_o=0001 one cycle after cyc; m_ack_o=0001 coincident with s_ack_i; m_dat_o=DEADBEEF.
- m_cyc_i=4'b1111 held, each master one transfer then drops cyc -> grants in order 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between each.
- Master 1 holds cyc for a 4-beat burst with stb gaps while master 0 requests -> master 0 is granted only after master 1 drops cyc; s_adr_o follows master 1 throughout.
- TIMEOUT=8, slave never acks -> m_err_o[g] pulses 1 cycle after 8 strobe cycles; s_stb_o low that cycle; no m_ack_o.
- Ack arrives on cycle TIMEOUT-1 -> m_ack_o asserted, m_err_o stays 0.
- Assert rst low mid-burst -> s_cyc_o, gnt_o and busy_o go 0 asynchronously; after release, master 0 has priority again.
